// File: rtl/spi_master_if.sv
// spi_master_if: host start/data/done handshake plus the four SPI pins of spi_master.
interface spi_master_if #(parameter int DATA_WIDTH = 8);
    logic                  start;
    logic [DATA_WIDTH-1:0] masterDataToSend;
    logic [DATA_WIDTH-1:0] masterDataReceived;
    logic                  busy;
    logic                  done;
    logic                  SCLK;
    logic                  CS;
    logic                  MOSI;
    logic                  MISO;
    modport master (
        input  start, masterDataToSend, MISO,
        output masterDataReceived, busy, done, SCLK, CS, MOSI
    );
    modport slave (
        output start, masterDataToSend, MISO,
        input  masterDataReceived, busy, done, SCLK, CS, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// spi_master: CPOL=0, LSB-first SPI initiator; one byte per start, CS framed, fully registered outputs.
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input logic          clk,
    input logic          reset,
    spi_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_e;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [8:0] DIV_M1  = 9'(CLK_DIV - 1);
    // HOLD spans the trailing SCLK-low half period plus the CS hold time
    localparam logic [8:0] HOLD_M1 = 9'(2 * CLK_DIV - 1);
    state_e                state_q, state_d;
    logic [8:0]            cnt_q, cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
    logic                  sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  tick;
    always_comb begin
        tick      = cnt_q == ((state_q == HOLD) ? HOLD_M1 : DIV_M1);
        state_d   = state_q;
        cnt_d     = tick ? 9'd0 : cnt_q + 9'd1;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 9'd0;
                if (bus.start) begin
                    tx_d      = bus.masterDataToSend;
                    mosi_d    = bus.masterDataToSend[0];
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP, LOW: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    sclk_d    = 1'b0;
                    rx_d      = {bus.MISO, rx_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q != LAST_BIT) begin
                        tx_d    = tx_q >> 1;
                        mosi_d  = tx_q[1];
                        state_d = LOW;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = rx_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
    assign bus.SCLK               = sclk_q;
    assign bus.CS                 = cs_q;
    assign bus.MOSI               = mosi_q;
    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.masterDataReceived = rdata_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed tests against a waveform-level model of spi_master plus a behavioural SPI slave.
module tb_spi_master;
    localparam int D = 2;
    localparam int W = 8;
    localparam int L = D * (2 * W + 2);
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    spi_master_if #(.DATA_WIDTH(W)) bus();
    spi_master #(.DATA_WIDTH(W), .CLK_DIV(D)) dut (.clk(clk), .reset(reset), .bus(bus));
    int checks = 0;
    int errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // behavioural slave: samples MOSI and shifts out MISO on SCLK rise, reloads on CS fall
    logic [7:0] slave_preload = 8'h00;
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    logic       miso_r = 1'b0;
    assign bus.MISO = miso_r;
    always @(negedge bus.CS) s_tx = slave_preload;
    always @(posedge bus.SCLK) begin
        miso_r = s_tx[0];
        s_tx   = s_tx >> 1;
        s_rx   = {bus.MOSI, s_rx[7:1]};
    end
    time t_fall = 0, t_rise = 0;
    int  cs_low = 0, cs_gap = 0, rises = 0, mosi_hi = 0, done_cnt = 0;
    always @(negedge bus.CS) begin
        t_fall = $time;
        cs_gap = int'(($time - t_rise) / 10);
        rises  = 0;
    end
    always @(posedge bus.CS) begin
        t_rise = $time;
        cs_low = int'(($time - t_fall) / 10);
    end
    always @(posedge bus.SCLK) rises++;
    always @(negedge clk) begin
        if (bus.CS === 1'b0 && bus.MOSI === 1'b1) mosi_hi++;
        if (bus.done === 1'b1) done_cnt++;
    end
    // model: t counts cycles since acceptance; 1..L is CS low, L+1 is the done cycle
    int         t = 0;
    logic [7:0] m_tx = 8'h00, m_exp = 8'h00, m_rd = 8'h00;
    always @(posedge clk) begin
        if (reset) begin
            t    = 0;
            m_rd = 8'h00;
        end else if ((t == 0 || t == L + 1) && bus.start) begin
            t     = 1;
            m_tx  = bus.masterDataToSend;
            m_exp = slave_preload;
        end else if (t == L + 1) begin
            t = 0;
        end else if (t != 0) begin
            t++;
            if (t == L + 1) m_rd = m_exp;
        end
    end
    always @(negedge clk) begin
        logic e_sclk, e_cs, e_mosi, e_busy, e_done;
        int u, b;
        e_sclk = 1'b0; e_cs = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (t == L + 1) begin
            e_done = 1'b1;
        end else if (t != 0) begin
            u      = t - 1;
            b      = (u / (2 * D) > W - 1) ? W - 1 : u / (2 * D);
            e_cs   = 1'b0;
            e_busy = 1'b1;
            e_sclk = (u >= D) && (u < D + 2 * D * W) && (((u - D) / D) % 2 == 0);
            e_mosi = m_tx[b];
        end
        chk("sclk", bus.SCLK, e_sclk);
        chk("cs", bus.CS, e_cs);
        chk("mosi", bus.MOSI, e_mosi);
        chk("busy", bus.busy, e_busy);
        chk("done", bus.done, e_done);
        chk("rdata", bus.masterDataReceived, m_rd);
    end
    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(n < 200), 1);
    endtask
    task automatic xfer(input logic [7:0] d, input logic [7:0] pre);
        @(negedge clk);
        slave_preload = pre;
        bus.masterDataToSend = d;
        bus.start = 1'b1;
        mosi_hi = 0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.masterDataToSend = ~d;
        wait_done();
        chk("rx_byte", bus.masterDataReceived, pre);
        chk("slave_rx", s_rx, d);
        chk("cs_low_cycles", cs_low, 36);
        chk("sclk_rises", rises, 8);
    endtask
    initial begin
        int n, d0;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.masterDataToSend = 8'hA5;
        repeat (2) begin
            @(negedge clk);
            chk("rst_sclk", bus.SCLK, 0);
            chk("rst_cs", bus.CS, 1);
            chk("rst_mosi", bus.MOSI, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_rdata", bus.masterDataReceived, 8'h00);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        xfer(8'hA5, 8'h3C);
        chk("rx_3c", bus.masterDataReceived, 8'h3C);
        xfer(8'h01, 8'h00);
        chk("mosi_hi_01", mosi_hi, 4);
        xfer(8'h80, 8'hFF);
        chk("mosi_hi_80", mosi_hi, 8);
        // start while busy must be ignored
        @(negedge clk);
        slave_preload = 8'hE7;
        bus.masterDataToSend = 8'h5A;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.masterDataToSend = 8'hFF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.masterDataToSend = 8'h00;
        wait_done();
        chk("busy_ign_slave", s_rx, 8'h5A);
        chk("busy_ign_rx", bus.masterDataReceived, 8'hE7);
        repeat (5) @(negedge clk);
        chk("no_second_xfer", bus.busy, 0);
        // start held high: back-to-back transfers
        d0 = done_cnt;
        @(negedge clk);
        slave_preload = 8'h3C;
        bus.masterDataToSend = 8'h11;
        bus.start = 1'b1;
        wait_done();
        chk("b2b_slave1", s_rx, 8'h11);
        chk("b2b_rx1", bus.masterDataReceived, 8'h3C);
        slave_preload = 8'h99;
        bus.masterDataToSend = 8'h22;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        chk("b2b_slave2", s_rx, 8'h22);
        chk("b2b_rx2", bus.masterDataReceived, 8'h99);
        chk("b2b_cs_gap", cs_gap, 1);
        @(negedge clk);
        chk("b2b_done_pulses", done_cnt - d0, 2);
        // reset after the third SCLK rise
        d0 = done_cnt;
        slave_preload = 8'h42;
        bus.masterDataToSend = 8'h5A;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (rises < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rise_timeout", 32'(n < 100), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_cs", bus.CS, 1);
        chk("mid_rst_sclk", bus.SCLK, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        xfer(8'h5A, 8'h24);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
